ecc_dec_pipe: RTL

ECC_DEC_PIPE -- requirements
Module: ecc_dec_pipe

---
 rtl/ecc_dec_pipe.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: two-stage syndrome decoder for 8/16/32-bit codewords.
// Stage 1 holds data/mode/syndrome, stage 2 holds corrected data/status.
module ecc_dec_pipe #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int AMBA_WORD          = 32,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [AMBA_WORD-1:0]          work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    num_of_errors,
  input  logic                          cnt_clr,
  output logic [CNT_WIDTH-1:0]          corr_cnt,
  output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

  localparam int W = MAX_CODEWORD_WIDTH;
  localparam int P = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

  localparam logic [47:0]  H8  = 48'h0000_FFE4_D2B1;
  localparam logic [95:0]  H16 =
    96'h0000_FFFF_FE08_F1C4_CDA2_AB61;
  localparam logic [191:0] H32 =
    192'hFFFF_FFFF_FFFE_0010_FF01_FC08_F0F1_E384_CCCD_9B42_AAAB_56C1;

  // Mode 3 means "illegal": all rows zero, no syndrome.
  function automatic logic [31:0] h_row(
    input logic [1:0] m,
    input int         r
  );
    logic [31:0] v;
    case (m)
      2'd0:    v = {24'd0, H8[r*8 +: 8]};
      2'd1:    v = {16'd0, H16[r*16 +: 16]};
      2'd2:    v = H32[r*32 +: 32];
      default: v = '0;
    endcase
    return v;
  endfunction

  logic           en;
  logic [1:0]     mode_d;
  logic [W-1:0]   mask_d;
  logic [W-1:0]   d1_d;
  logic [P-1:0]   syn_d;

  logic           v1_q;
  logic [W-1:0]   d1_q;
  logic [1:0]     m1_q;
  logic [P-1:0]   syn1_q;

  logic [W-1:0]   rows1 [P];
  logic [P-1:0]   col;
  logic [W-1:0]   flip;
  logic           hit;
  logic [W-1:0]   data2_d;
  logic [1:0]     err2_d;

  logic           v2_q;
  logic [W-1:0]   data2_q;
  logic [1:0]     err2_q;

  logic [CNT_WIDTH-1:0] corr_q;
  logic [CNT_WIDTH-1:0] uncorr_q;

  assign en       = !v2_q || out_ready;
  assign in_ready = rst || en;

  assign mode_d = (work_mod > AMBA_WORD'(2)) ? 2'd3 : work_mod[1:0];

  // Length mask: bits at and above L are dropped for legal modes.
  always_comb begin
    mask_d = '1;
    case (mode_d)
      2'd0:    mask_d = W'(32'h0000_00FF);
      2'd1:    mask_d = W'(32'h0000_FFFF);
      default: mask_d = '1;
    endcase
  end

  assign d1_d = data_in & mask_d;

  // Row-wise parity of the received word gives the syndrome.
  always_comb begin
    syn_d = '0;
    for (int r = 0; r < P; r++) begin
      syn_d[r] = ^(W'(h_row(mode_d, r)) & d1_d);
    end
  end

  // Stage 1: capture masked data, mode and syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      m1_q   <= 2'd0;
      syn1_q <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        d1_q   <= d1_d;
        m1_q   <= mode_d;
        syn1_q <= syn_d;
      end
    end
  end

  // H rows for the word sitting in stage 1.
  always_comb begin
    for (int r = 0; r < P; r++) begin
      rows1[r] = W'(h_row(m1_q, r));
    end
  end

  // Find the column equal to the syndrome and flip that bit.
  always_comb begin
    flip = '0;
    hit  = 1'b0;
    col  = '0;
    for (int c = 0; c < W; c++) begin
      for (int r = 0; r < P; r++) begin
        col[r] = rows1[r][c];
      end
      if (syn1_q != '0 && col == syn1_q) begin
        flip[c] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  // Status encoding for the stage-2 result.
  always_comb begin
    data2_d = d1_q ^ flip;
    err2_d  = 2'b10;
    if (m1_q == 2'd3) begin
      data2_d = d1_q;
      err2_d  = 2'b11;
    end else if (syn1_q == '0) begin
      err2_d  = 2'b00;
    end else if (hit) begin
      err2_d  = 2'b01;
    end
  end

  // Stage 2: corrected data and status, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      data2_q <= '0;
      err2_q  <= 2'b00;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data2_q <= data2_d;
        err2_q  <= err2_d;
      end
    end
  end

  // Saturating counters on delivered results; clear wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (v2_q && out_ready) begin
      if (err2_q == 2'b01) begin
        if (corr_q != '1) corr_q <= corr_q + 1'b1;
      end else if (err2_q[1]) begin
        if (uncorr_q != '1) uncorr_q <= uncorr_q + 1'b1;
      end
    end
  end

  assign out_valid     = v2_q;
  assign data_out      = data2_q;
  assign num_of_errors = err2_q;
  assign corr_cnt      = corr_q;
  assign uncorr_cnt    = uncorr_q;

endmodule
